// File: rtl/hafsa_sopc_cpu_oci_dct_pkg.sv
// Shared constants and types for the OCI compressed-trace (DCT) frame packer.
package hafsa_sopc_cpu_oci_dct_pkg;

  localparam int ATOM_W    = 2;
  localparam int DCT_DEPTH = 15;
  localparam int DCT_BUF_W = ATOM_W * DCT_DEPTH;
  localparam int DCT_CNT_W = 4;

  typedef logic [ATOM_W-1:0]    atom_t;
  typedef logic [DCT_BUF_W-1:0] frame_t;
  typedef logic [DCT_CNT_W-1:0] cnt_t;

  localparam atom_t ATOM_PAD = 2'b00;
  localparam atom_t ATOM_NT  = 2'b01;
  localparam atom_t ATOM_TK  = 2'b10;
  localparam atom_t ATOM_EXC = 2'b11;

  localparam cnt_t DCT_FULL_CNT = cnt_t'(DCT_DEPTH);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_ENDED  = 2'd2
  } dct_state_e;

endpackage

// File: rtl/hafsa_sopc_cpu_oci_dct_packer_if.sv
// Atom input, frame output and end-of-test signals of the DCT packer.
interface hafsa_sopc_cpu_oci_dct_packer_if;
  import hafsa_sopc_cpu_oci_dct_pkg::*;

  logic   atom_valid;
  atom_t  atom_data;
  logic   atom_ready;
  logic   flush;
  logic   test_ending;
  logic   dct_valid;
  logic   dct_ready;
  frame_t dct_buffer;
  cnt_t   dct_count;
  logic   test_has_ended;

  // master: trace compressor + trace sink side; slave: the packer itself
  modport master (
    output atom_valid, atom_data, flush, test_ending, dct_ready,
    input  atom_ready, dct_valid, dct_buffer, dct_count, test_has_ended
  );

  modport slave (
    input  atom_valid, atom_data, flush, test_ending, dct_ready,
    output atom_ready, dct_valid, dct_buffer, dct_count, test_has_ended
  );

endinterface

// File: rtl/hafsa_sopc_cpu_oci_dct_slot.sv
// One-entry valid/ready holding register presenting a packed frame to the sink.
module hafsa_sopc_cpu_oci_dct_slot
  import hafsa_sopc_cpu_oci_dct_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   load,
  input  frame_t load_data,
  input  cnt_t   load_count,
  input  logic   dct_ready,
  output logic   dct_valid,
  output frame_t dct_buffer,
  output cnt_t   dct_count
);

  logic   valid_q, valid_d;
  frame_t buffer_q, buffer_d;
  cnt_t   count_q, count_d;

  // A load wins over a same-cycle drain so frames can stream every cycle.
  always_comb begin
    valid_d  = valid_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    if (load) begin
      valid_d  = 1'b1;
      buffer_d = load_data;
      count_d  = load_count;
    end else if (valid_q && dct_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q  <= 1'b0;
      buffer_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
    end
  end

  assign dct_valid  = valid_q;
  assign dct_buffer = buffer_q;
  assign dct_count  = count_q;

endmodule

// File: rtl/hafsa_sopc_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 30-bit DCT frames and sequences end-of-test draining.
module hafsa_sopc_cpu_oci_dct_packer
  import hafsa_sopc_cpu_oci_dct_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset_n,
  hafsa_sopc_cpu_oci_dct_packer_if.slave   bus
);

  frame_t     acc_q, acc_d;
  cnt_t       cnt_q, cnt_d;
  logic       flush_pend_q, flush_pend_d;
  dct_state_e state_q, state_d;
  logic       test_has_ended_q, test_has_ended_d;

  logic   slot_valid;
  frame_t slot_buffer;
  cnt_t   slot_count;

  logic   full;
  logic   flush_mode;
  logic   xfer;
  logic   atom_ready_w;
  logic   accept;
  frame_t acc_base;
  cnt_t   cnt_base;

  // DRAIN behaves like a permanently pending flush.
  assign full         = (cnt_q == DCT_FULL_CNT);
  assign flush_mode   = flush_pend_q || (state_q == ST_DRAIN);
  assign xfer         = (full || (flush_mode && (cnt_q != '0))) &&
                        (!slot_valid || bus.dct_ready);
  assign atom_ready_w = (state_q == ST_ACTIVE) && (!full || xfer);
  assign accept       = bus.atom_valid && atom_ready_w;

  // On a transfer the accumulator restarts, so a same-cycle atom lands in acc[1:0].
  always_comb begin
    acc_base = xfer ? '0 : acc_q;
    cnt_base = xfer ? '0 : cnt_q;
    acc_d    = acc_base;
    cnt_d    = cnt_base;
    if (accept) begin
      acc_d = {acc_base[DCT_BUF_W-ATOM_W-1:0], bus.atom_data};
      cnt_d = cnt_base + cnt_t'(1);
    end
  end

  // A pending flush with nothing to send evaporates, so no empty frames.
  always_comb begin
    flush_pend_d = 1'b0;
    if (!xfer && (state_q != ST_ENDED))
      flush_pend_d = (flush_pend_q || bus.flush) && (cnt_d != '0);
  end

  always_comb begin
    state_d          = state_q;
    test_has_ended_d = test_has_ended_q;
    case (state_q)
      ST_ACTIVE: begin
        if (bus.test_ending)
          state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((cnt_q == '0) && !slot_valid) begin
          state_d          = ST_ENDED;
          test_has_ended_d = 1'b1;
        end
      end
      ST_ENDED: begin
        test_has_ended_d = 1'b1;
      end
      default: begin
        state_d = ST_ACTIVE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q            <= '0;
      cnt_q            <= '0;
      flush_pend_q     <= 1'b0;
      state_q          <= ST_ACTIVE;
      test_has_ended_q <= 1'b0;
    end else begin
      acc_q            <= acc_d;
      cnt_q            <= cnt_d;
      flush_pend_q     <= flush_pend_d;
      state_q          <= state_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

  hafsa_sopc_cpu_oci_dct_slot u_slot (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (xfer),
    .load_data  (acc_q),
    .load_count (cnt_q),
    .dct_ready  (bus.dct_ready),
    .dct_valid  (slot_valid),
    .dct_buffer (slot_buffer),
    .dct_count  (slot_count)
  );

  assign bus.atom_ready     = atom_ready_w;
  assign bus.dct_valid      = slot_valid;
  assign bus.dct_buffer     = slot_buffer;
  assign bus.dct_count      = slot_count;
  assign bus.test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_hafsa_sopc_cpu_oci_dct_packer.sv
// Randomised and directed bench for the DCT packer against a queue-based frame model.
module tb_hafsa_sopc_cpu_oci_dct_packer;
  import hafsa_sopc_cpu_oci_dct_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  hafsa_sopc_cpu_oci_dct_packer_if bus ();

  hafsa_sopc_cpu_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // reference model: atoms waiting in the accumulator, frame slot, phase
  logic [1:0]  m_q[$];
  bit          m_fp;
  bit          m_sv;
  logic [29:0] m_buf;
  int          m_cnt;
  int          m_ph;      // 0 active, 1 draining, 2 ended
  bit          m_ended;
  int          dut_accepted;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [29:0] pack_q();
    logic [29:0] p = '0;
    int n = m_q.size();
    for (int i = 0; i < n; i++)
      p = p | (30'(m_q[i]) << (2 * (n - 1 - i)));
    return p;
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_fp    = 0;
    m_sv    = 0;
    m_buf   = '0;
    m_cnt   = 0;
    m_ph    = 0;
    m_ended = 0;
  endfunction

  task automatic check_outputs(input string pfx);
    check_val({pfx, "_valid"}, bus.dct_valid, m_sv);
    check_val({pfx, "_buf"}, bus.dct_buffer, m_buf);
    check_val({pfx, "_cnt"}, bus.dct_count, m_cnt);
    check_val({pfx, "_ended"}, bus.test_has_ended, m_ended);
  endtask

  // one clock cycle: entered and left just after a falling edge
  task automatic step(input bit av, input logic [1:0] ad, input bit fl, input bit te, input bit dr);
    int  n;
    bit  due, xf, rdy, acc, old_sv;
    bus.atom_valid  = av;
    bus.atom_data   = ad;
    bus.flush       = fl;
    bus.test_ending = te;
    bus.dct_ready   = dr;
    #1;
    n   = m_q.size();
    due = (n == 15) || ((m_fp || m_ph == 1) && n > 0);
    xf  = due && (!m_sv || dr);
    rdy = (m_ph == 0) && (n < 15 || xf);
    acc = av && rdy;
    check_val("atom_ready", bus.atom_ready, rdy);
    if (av && bus.atom_ready) dut_accepted++;
    old_sv = m_sv;
    if (xf) begin
      m_buf = pack_q();
      m_cnt = n;
      m_sv  = 1;
      m_q.delete();
    end else if (m_sv && dr) begin
      m_sv = 0;
    end
    if (acc) m_q.push_back(ad);
    if (xf || m_ph == 2) m_fp = 0;
    else                 m_fp = (m_fp || fl) && (m_q.size() > 0);
    if (m_ph == 0 && te) m_ph = 1;
    else if (m_ph == 1 && n == 0 && !old_sv) begin
      m_ph    = 2;
      m_ended = 1;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic apply_reset();
    bus.atom_valid  = 0;
    bus.atom_data   = '0;
    bus.flush       = 0;
    bus.test_ending = 0;
    bus.dct_ready   = 0;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    dut_accepted = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected end by 1000000");
    $fatal(1);
  end

  initial begin
    int guard;
    reset_n = 1'b1;
    bus.atom_valid = 0; bus.atom_data = '0; bus.flush = 0;
    bus.test_ending = 0; bus.dct_ready = 0;
    model_reset();
    dut_accepted = 0;
    #2;
    apply_reset();

    // full frame of taken atoms, sink always ready
    for (int i = 0; i < 15; i++) step(1, ATOM_TK, 0, 0, 1);
    check_val("full_pre_valid", bus.dct_valid, 0);
    step(0, '0, 0, 0, 1);
    check_val("full_valid", bus.dct_valid, 1);
    check_val("full_buf", bus.dct_buffer, 32'h2AAAAAAA);
    check_val("full_cnt", bus.dct_count, 15);

    // partial frame via flush, then a flush with nothing buffered
    step(1, ATOM_NT, 0, 0, 1);
    step(1, ATOM_TK, 0, 0, 1);
    step(1, ATOM_EXC, 0, 0, 1);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    check_val("flush_valid", bus.dct_valid, 1);
    check_val("flush_buf", bus.dct_buffer, 32'h1B);
    check_val("flush_cnt", bus.dct_count, 3);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check_val("empty_flush_valid", bus.dct_valid, 0);

    // backpressure: 30 atoms fill slot and accumulator, then stall
    apply_reset();
    for (int i = 0; i < 40; i++) step(1, ATOM_NT, 0, 0, 0);
    check_val("bp_accepted", dut_accepted, 30);
    check_val("bp_ready_low", bus.atom_ready, 0);
    check_val("bp_held_buf", bus.dct_buffer, 32'h15555555);
    step(0, '0, 0, 0, 1);
    check_val("bp_second_valid", bus.dct_valid, 1);
    check_val("bp_second_buf", bus.dct_buffer, 32'h15555555);
    step(0, '0, 0, 0, 1);
    check_val("bp_drained", bus.dct_valid, 0);

    // transfer and atom acceptance in the same cycle
    apply_reset();
    guard = 0;
    while (dut_accepted < 30 && guard < 40) begin
      step(1, ATOM_NT, 0, 0, 0);
      guard++;
    end
    check_val("sim_fill", dut_accepted, 30);
    step(1, ATOM_EXC, 0, 0, 1);
    check_val("sim_accept", dut_accepted, 31);
    check_val("sim_cnt", bus.dct_count, 15);
    step(0, '0, 1, 0, 1);
    step(0, '0, 0, 0, 1);
    check_val("sim_new_valid", bus.dct_valid, 1);
    check_val("sim_new_buf", bus.dct_buffer, 32'h3);
    check_val("sim_new_cnt", bus.dct_count, 1);

    // end of test with a stalled sink
    apply_reset();
    for (int i = 0; i < 5; i++) step(1, 2'($urandom), 0, 0, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    check_val("eot_valid", bus.dct_valid, 1);
    check_val("eot_cnt", bus.dct_count, 5);
    step(1, ATOM_TK, 0, 1, 0);
    step(1, ATOM_TK, 0, 1, 0);
    check_val("eot_ready_low", bus.atom_ready, 0);
    guard = 0;
    while (!bus.test_has_ended && guard < 10) begin
      step(0, '0, 0, 1, 1);
      guard++;
    end
    check_val("eot_ended", bus.test_has_ended, 1);
    for (int i = 0; i < 3; i++) step(1, ATOM_NT, 1, 0, 1);
    check_val("eot_sticky", bus.test_has_ended, 1);

    // asynchronous reset in the middle of draining
    apply_reset();
    guard = 0;
    while (!(m_q.size() == 7 && m_sv) && guard < 40) begin
      step(1, 2'($urandom), 0, 0, 0);
      guard++;
    end
    check_val("mid_setup", (m_q.size() == 7 && m_sv), 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    @(posedge clk);
    #2;
    apply_reset();
    for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 0, 1);
    step(0, '0, 0, 0, 1);
    check_val("post_rst_cnt", bus.dct_count, 15);

    // randomised traffic, restarting after each completed end-of-test
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (m_ended && ($urandom_range(0, 7) == 0)) apply_reset();
      step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 199) == 0 || (m_ph != 0 && $urandom_range(0, 1) == 0),
           $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hafsa_sopc_cpu_oci_dct_packer.md
Name: hafsa_sopc_cpu_oci_dct_packer

Overview:
Producer end of the CPU OCI compressed-trace (DCT) frame interface. It accepts 2-bit trace atoms from the trace compressor and packs up to 15 of them into a 30-bit frame. It presents each frame as dct_buffer/dct_count with a valid/ready handshake to the OCI trace sink. It also owns end-of-test sequencing: on test_ending it drains, then raises test_has_ended.

Parameters:
ATOM_W, 2, bits per trace atom
DEPTH, 15, atoms per full frame
BUF_W, 30, frame width (ATOM_W*DEPTH); fixed to match the sink
CNT_W, 4, width of atom count (must hold DEPTH)

Ports:
clk  in  1  single clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
atom_valid  in  1  producer has an atom
atom_data  in  ATOM_W  atom code (00 pad/reserved, 01 not-taken, 10 taken, 11 exception)
atom_ready  out  1  atom accepted when atom_valid && atom_ready
flush  in  1  single-cycle request to emit a partial frame
test_ending  in  1  level; end of test requested
dct_valid  out  1  frame slot holds a frame
dct_ready  in  1  sink accepts the frame when dct_valid && dct_ready
dct_buffer  out  BUF_W  packed frame
dct_count  out  CNT_W  number of valid atoms in dct_buffer, 1..15 while dct_valid
test_has_ended  out  1  sticky; all trace is drained after test_ending

Behaviour:
- Reset (async, reset_n=0): accumulator acc=0, cnt=0, flush_pend=0, dct_valid=0, dct_buffer=0, dct_count=0, test_has_ended=0, FSM=ACTIVE. Reset mid-frame discards all data, including a held frame and a latched ending.
- Packing: an accepted atom gives acc <= {acc[BUF_W-ATOM_W-1:0], atom_data} and cnt <= cnt+1. The first atom ends up most significant. Unused upper bits stay 0; e.g. atoms a,b,c give {24'b0,a,b,c} with count 3. Atom code 00 is packed as-is; no filtering.
- Transfer (xfer), acc to slot: condition is (cnt==DEPTH || (flush_pend && cnt!=0)) && (!dct_valid || dct_ready).
  - On xfer: dct_buffer<=acc, dct_count<=cnt, dct_valid<=1.
  - Also on xfer: acc<=0, cnt<=0, flush_pend<=0.
- Slot: dct_valid clears when dct_ready && dct_valid && !xfer. Back-to-back frames are allowed every cycle. Slot outputs are registered and stable while dct_valid && !dct_ready.
- atom_ready = (FSM==ACTIVE) && (cnt<DEPTH || xfer). This is combinational from state and dct_ready.
- Simultaneous atom and xfer: the accumulator restarts with the new atom, giving cnt=1 with the atom in acc[1:0]. Latency from the 15th atom's acceptance to dct_valid is 1 cycle if the slot is free.
- flush:
  - Sets flush_pend; flush_pend holds until xfer.
  - If cnt==0 and no atom is accepted this cycle, flush_pend clears (no empty frames).
  - An atom accepted in the same cycle as the flush pulse is included in the flushed frame.
  - A flush while cnt==DEPTH is redundant, with no extra frame.
- FSM:
  - ACTIVE: on test_ending=1, go to DRAIN. atom_ready drops from the next cycle; atoms accepted in the transition cycle are kept.
  - DRAIN: behaves as if flush_pend=1 continuously. When cnt==0 && !dct_valid, go to ENDED.
  - ENDED: test_has_ended=1 (registered, sticky until reset); atom_ready=0; flush ignored.
- test_ending deasserting after being seen has no effect.
- cnt never exceeds DEPTH. The accumulator is never overwritten while full and the slot is busy; backpressure propagates via atom_ready.

Decomposition:
- Package hafsa_sopc_cpu_oci_dct_pkg:
  - atom code constants (ATOM_PAD, ATOM_NT, ATOM_TK, ATOM_EXC);
  - DCT_DEPTH=15, DCT_BUF_W=30, DCT_CNT_W=4;
  - FSM state encodings ST_ACTIVE, ST_DRAIN, ST_ENDED.
- One sub-module: hafsa_sopc_cpu_oci_dct_slot, a one-entry valid/ready holding register (load, data, count in; dct_* out).

Test Plan:
- Full frame, sink always ready: 15 atoms 10, one per cycle.
  - Expect dct_valid 1 cycle after the 15th acceptance, dct_buffer=30'h2AAAAAAA, dct_count=15, atom_ready never low.
- Partial flush: atoms 01,10,11, then a flush pulse.
  - Expect one frame dct_buffer=30'h1B, dct_count=3; a second flush with cnt==0 produces no frame.
- Backpressure: dct_ready=0, 30 atoms 01 offered.
  - Expect the first frame held stable and atom_ready=0 after 30 accepted (cnt=15, slot full).
  - When dct_ready=1, expect the frames to be delivered on consecutive cycles.
- Simultaneous xfer and atom: slot busy, cnt=15, then dct_ready=1 in the same cycle as atom 11.
  - Expect the new frame loaded, and acc=30'h3 with cnt=1 the next cycle.
- End of test: 5 atoms then test_ending=1, sink stalls 3 cycles.
  - Expect atom_ready=0 and a frame with count 5.
  - Expect test_has_ended to rise 1 cycle after the slot empties and stay high after test_ending drops.
- Reset mid-operation: reset_n low with cnt=7, dct_valid=1 and FSM=DRAIN.
  - Expect all outputs immediately 0 (async) and normal packing after release.
